// File: rtl/axis_jtag_arbiter.sv
// Round-robin arbiter sharing one AXIS-to-JTAG engine between two AXIS command sources.
// Grants are held for a whole packet, then a drain period lets the engine finish shifting.
module axis_jtag_arbiter #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH = 64,
  parameter int unsigned C_DRAIN_CYCLES      = 320
) (
  input  logic                           s_axis_aclk,
  input  logic                           s_axis_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                           s0_axis_tvalid,
  input  logic                           s0_axis_tlast,
  output logic                           s0_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                           s1_axis_tvalid,
  input  logic                           s1_axis_tlast,
  output logic                           s1_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           channel,
  output logic                           busy
);

  localparam int unsigned CntW = $clog2(C_DRAIN_CYCLES + 1);
  localparam logic [CntW-1:0] DrainLoad = CntW'(C_DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

  state_e          state_q, state_d;
  logic            channel_q, channel_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            grant_next;
  logic            fwd_valid;
  logic            fwd_last;

  // channel_q doubles as the current grant: both only change on the IDLE->GRANT edge.
  always_comb begin
    state_d        = state_q;
    channel_d      = channel_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    fwd_valid      = channel_q ? s1_axis_tvalid : s0_axis_tvalid;
    fwd_last       = channel_q ? s1_axis_tlast : s0_axis_tlast;
    grant_next     = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_q : s1_axis_tvalid;

    unique case (state_q)
      StIdle: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          state_d   = StGrant;
          channel_d = grant_next;
          last_d    = grant_next;
        end
      end
      StGrant: begin
        m_axis_tdata   = channel_q ? s1_axis_tdata : s0_axis_tdata;
        m_axis_tvalid  = fwd_valid;
        s0_axis_tready = ~channel_q & m_axis_tready;
        s1_axis_tready = channel_q & m_axis_tready;
        if (fwd_valid && m_axis_tready && fwd_last) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q   <= StIdle;
      channel_q <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      channel_q <= channel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign channel = channel_q;
  assign busy    = (state_q != StIdle);

endmodule
